// File: rtl/spi_pkg.sv
// Shared types and frame constants for the SPI responder register file.
package spi_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  // Bit positions within a frame, counted from the first bit sampled with cs low
  localparam int unsigned WR_BIT_POS   = 0;
  localparam int unsigned ADDR_LSB_POS = 1;
  localparam int unsigned DATA_LSB_POS = ADDR_LSB_POS + ADDR_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    WDATA  = 3'd2,
    RREADY = 3'd3,
    RDATA  = 3'd4,
    DONE   = 3'd5,
    HOLD   = 3'd6
  } state_t;

endpackage

// File: rtl/spi_rx_shift.sv
// LSB-first 8-bit deserializer; word_next/last expose the completed word on the final shift edge.
module spi_rx_shift
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [DATA_W-1:0] word_next,
  output logic              last
);

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [2:0]        cnt_q, cnt_d;

  assign word_next = {din, sh_q[DATA_W-1:1]};
  assign last      = en && (cnt_q == 3'd7);

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (clr) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (en) begin
      sh_d  = word_next;
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_resp_regfile.sv
// SPI responder: decodes wr/addr/data frames on mosi and serves an 8-bit register file.
module spi_resp_regfile
  import spi_pkg::*;
#(
  parameter int unsigned       DEPTH   = 32,
  parameter logic [DATA_W-1:0] RST_VAL = 8'h00
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic ready,
  output logic op_done,
  output logic err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        rd_cnt_q, rd_cnt_d;
  logic              miso_q, miso_d, ready_q, ready_d;
  logic              op_done_q, op_done_d, err_q, err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              rx_clr, rx_en, rx_last;
  logic [DATA_W-1:0] rx_word;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  // The range check uses all 8 address bits, so aliases above DEPTH never hit storage
  assign in_range = (32'(addr_q) < DEPTH);
  assign idx      = addr_q[IDX_W-1:0];

  spi_rx_shift u_rx (
    .clk       (clk),
    .rst       (rst),
    .clr       (rx_clr),
    .en        (rx_en),
    .din       (mosi),
    .word_next (rx_word),
    .last      (rx_last)
  );

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    shift_d  = shift_q;
    rd_cnt_d = rd_cnt_q;
    mem_d    = mem_q;
    rx_clr   = 1'b0;
    rx_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        rx_clr = 1'b1;
        if (!cs) begin
          wr_d    = mosi;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (cs) state_d = IDLE;
        else begin
          rx_en = 1'b1;
          if (rx_last) begin
            addr_d  = rx_word;
            state_d = wr_q ? WDATA : RREADY;
          end
        end
      end
      WDATA: begin
        if (cs) state_d = IDLE;
        else begin
          rx_en = 1'b1;
          if (rx_last) begin
            if (in_range) mem_d[idx] = rx_word;
            state_d = DONE;
          end
        end
      end
      RREADY: begin
        if (cs) state_d = IDLE;
        else begin
          shift_d  = in_range ? mem_q[idx] : '0;
          rd_cnt_d = '0;
          state_d  = RDATA;
        end
      end
      RDATA: begin
        if (cs) state_d = IDLE;
        else if (rd_cnt_q == 3'd7) state_d = DONE;
        else begin
          shift_d  = shift_q >> 1;
          rd_cnt_d = rd_cnt_q + 3'd1;
        end
      end
      DONE:    state_d = HOLD;
      HOLD:    if (cs) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it
    miso_d    = (state_d == RDATA) ? shift_d[0] : 1'b0;
    ready_d   = (state_d == RREADY);
    op_done_d = (state_d == DONE);
    err_d     = op_done_d && !in_range;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      shift_q   <= '0;
      rd_cnt_q  <= '0;
      miso_q    <= 1'b0;
      ready_q   <= 1'b0;
      op_done_q <= 1'b0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= RST_VAL;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      shift_q   <= shift_d;
      rd_cnt_q  <= rd_cnt_d;
      miso_q    <= miso_d;
      ready_q   <= ready_d;
      op_done_q <= op_done_d;
      err_q     <= err_d;
      mem_q     <= mem_d;
    end
  end

  assign miso    = miso_q;
  assign ready   = ready_q;
  assign op_done = op_done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_spi_resp_regfile.sv
// Self-checking bench for spi_resp_regfile: directed vector table, corner sequences, random frames vs. a memory model.
module tb_spi_resp_regfile;

  localparam int unsigned DEPTH = 32;

  logic clk = 1'b0;
  logic rst, cs, mosi;
  logic miso, ready, op_done, err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_mem [256];

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    bit         exp_err;
  } vec_t;

  vec_t vecs [13];

  spi_resp_regfile #(.DEPTH(DEPTH), .RST_VAL(8'h00)) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .mosi    (mosi),
    .miso    (miso),
    .ready   (ready),
    .op_done (op_done),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_in_range(input logic [7:0] a);
    return int'(a) < int'(DEPTH);
  endfunction

  // One full frame; cs stays low for hold_low cycles after op_done before release
  task automatic do_frame(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                          input logic [7:0] exp_rd, input bit exp_err, input int hold_low,
                          input string tag);
    logic       early;
    logic [7:0] got;
    early = 1'b0;
    got   = '0;
    cs = 1'b0; mosi = wr; tick();
    for (int i = 0; i < 8; i++) begin
      mosi = addr[i]; tick();
      if (i < 7 && (ready || op_done || miso)) early = 1'b1;
    end
    chk({tag, "_addr_quiet"}, {31'b0, early}, 32'd0);
    if (wr) begin
      chk({tag, "_w_noready"}, {31'b0, ready}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        mosi = data[i]; tick();
        if (i < 7 && (ready || op_done || miso)) early = 1'b1;
      end
      chk({tag, "_wdata_quiet"}, {31'b0, early}, 32'd0);
    end else begin
      chk({tag, "_ready"}, {31'b0, ready}, 32'd1);
      chk({tag, "_rready_miso"}, {31'b0, miso}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        mosi = 1'($urandom); tick();
        got[i] = miso;
        if (ready || op_done) early = 1'b1;
      end
      chk({tag, "_rdata"}, {24'b0, got}, {24'b0, exp_rd});
      chk({tag, "_rdata_quiet"}, {31'b0, early}, 32'd0);
      tick();
    end
    chk({tag, "_op_done"}, {31'b0, op_done}, 32'd1);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    chk({tag, "_done_ready"}, {30'b0, ready, miso}, 32'd0);
    for (int i = 0; i < hold_low; i++) begin
      mosi = 1'($urandom); tick();
      chk({tag, "_hold_quiet"}, {29'b0, ready, op_done, miso}, 32'd0);
    end
    cs = 1'b1; tick(); tick();
    chk({tag, "_idle_quiet"}, {28'b0, ready, op_done, err, miso}, 32'd0);
    if (wr && model_in_range(addr)) model_mem[addr] = data;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'd5,   8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 8'd3,   8'hA5, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 8'd3,   8'h00, 8'hA5, 1'b0};
    vecs[3]  = '{1'b1, 8'd40,  8'h3C, 8'h00, 1'b1};
    vecs[4]  = '{1'b0, 8'd40,  8'h00, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 8'd3,   8'h00, 8'hA5, 1'b0};
    vecs[6]  = '{1'b1, 8'd31,  8'hFF, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 8'd31,  8'h00, 8'hFF, 1'b0};
    vecs[8]  = '{1'b1, 8'd32,  8'h11, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 8'd32,  8'h00, 8'h00, 1'b1};
    vecs[10] = '{1'b0, 8'd255, 8'h00, 8'h00, 1'b1};
    vecs[11] = '{1'b1, 8'd0,   8'h01, 8'h00, 1'b0};
    vecs[12] = '{1'b0, 8'd0,   8'h00, 8'h01, 1'b0};

    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    rst = 1'b0; cs = 1'b1; mosi = 1'b0;
    tick(); tick();
    chk("reset_outputs", {28'b0, miso, ready, op_done, err}, 32'd0);
    rst = 1'b1;
    tick();

    foreach (vecs[i])
      do_frame(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_rd, vecs[i].exp_err,
               0, $sformatf("vec%0d", i));

    // Abort a write to addr 7 after its 4th address bit
    do_frame(1'b1, 8'd7, 8'h5A, 8'h00, 1'b0, 0, "pre_abort");
    cs = 1'b0; mosi = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin mosi = (i == 0 || i == 1 || i == 2); tick(); end
    cs = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mosi = 1'($urandom); tick();
      chk("abort_quiet", {29'b0, ready, op_done, miso}, 32'd0);
    end
    do_frame(1'b0, 8'd7, 8'h00, 8'h5A, 1'b0, 0, "post_abort");

    // cs held low after op_done must not start another frame
    do_frame(1'b1, 8'd9, 8'hC3, 8'h00, 1'b0, 14, "hold_long");
    do_frame(1'b0, 8'd9, 8'h00, 8'hC3, 1'b0, 12, "hold_read");

    // Asynchronous reset in the middle of RDATA
    cs = 1'b0; mosi = 1'b0; tick();
    for (int i = 0; i < 8; i++) begin mosi = (i == 0 || i == 1); tick(); end
    chk("rst_pre_ready", {31'b0, ready}, 32'd1);
    tick();
    chk("rst_pre_miso", {31'b0, miso}, 32'd1);
    #2 rst = 1'b0;
    #1 chk("rst_async_outputs", {28'b0, miso, ready, op_done, err}, 32'd0);
    cs = 1'b1;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    tick();
    do_frame(1'b0, 8'd3, 8'h00, 8'h00, 1'b0, 0, "post_rst3");
    do_frame(1'b0, 8'd9, 8'h00, 8'h00, 1'b0, 0, "post_rst9");

    for (int n = 0; n < 40; n++) begin
      bit         w;
      logic [7:0] a, d;
      w = 1'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 39));
      d = 8'($urandom);
      do_frame(w, a, d, model_in_range(a) ? model_mem[a] : 8'h00, !model_in_range(a),
               int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
